// File: rtl/coin_key_filter.sv
// Coin pushbutton conditioning: per-key sync + symmetric debounce, one confirm per press,
// and a registered arbiter that serialises simultaneous confirms into single-cycle coin codes.

module coin_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic confirm
);
    // state   | meaning
    // REL     | key released and stable
    // PRESS_W | sync low seen, counting consecutive low samples
    // PRESSED | press confirmed, waiting for release
    // REL_W   | sync high seen, counting consecutive high samples

    typedef enum logic [1:0] {REL, PRESS_W, PRESSED, REL_W} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    logic             key_meta;
    logic             key_sync;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= REL;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The counter stops at DEBOUNCE_CYCLES on the confirming sample and is
    // cleared on every entry to a waiting state, so it can never wrap.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            REL: begin
                if (!key_sync) begin
                    state_next = PRESS_W;
                    cnt_next   = '0;
                end
            end
            PRESS_W: begin
                if (key_sync) begin
                    state_next = REL;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = CNT_MAX;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (key_sync) begin
                    state_next = REL_W;
                    cnt_next   = '0;
                end
            end
            REL_W: begin
                if (!key_sync) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = REL;
                    cnt_next   = CNT_MAX;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = REL;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        confirm = (state == PRESS_W) && !key_sync && (cnt == CNT_LAST);
    end

endmodule

module coin_key_filter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_05_n,
    input  logic       key_10_n,
    output logic [1:0] coin
);
    logic       confirm_05;
    logic       confirm_10;
    logic       pend_05;
    logic       pend_10;
    logic       pend_05_next;
    logic       pend_10_next;
    logic [1:0] coin_next;
    logic       req_05;
    logic       req_10;

    coin_key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_05 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_n     (key_05_n),
        .confirm   (confirm_05)
    );

    coin_key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_10 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_n     (key_10_n),
        .confirm   (confirm_10)
    );

    // A fresh confirm is served directly; a confirm arriving while its own
    // pending flag is being served re-arms that flag so the coin is not lost.
    always_comb begin
        req_05       = pend_05 | confirm_05;
        req_10       = pend_10 | confirm_10;
        coin_next    = 2'b00;
        pend_05_next = 1'b0;
        pend_10_next = 1'b0;
        if (req_10) begin
            coin_next    = 2'b10;
            pend_10_next = pend_10 & confirm_10;
            pend_05_next = req_05;
        end else if (req_05) begin
            coin_next    = 2'b01;
            pend_05_next = pend_05 & confirm_05;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            coin    <= 2'b00;
            pend_05 <= 1'b0;
            pend_10 <= 1'b0;
        end else begin
            coin    <= coin_next;
            pend_05 <= pend_05_next;
            pend_10 <= pend_10_next;
        end
    end

endmodule
